io_input_ctrl: RTL and testbench

Memory-mapped input controller that sits between the board's physical inputs (24 switches, 5 push buttons) and the CPU's IO read path, and is the receive end of the switch/button stimulus driven by the board or testbench. Each input is synchronised, each button is debounced, and button presses are latched as sticky events. The CPU reads live state, events and a press counter through a registered, clear-on-read register window.

---
 rtl/io_input_ctrl.sv | 107 ++++++++++
 tb/tb_io_input_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: synchronised/debounced switch+button reader with clear-on-read IO window; IO_INPUT_SWITCH_DEBOUNCE_EN also debounces switches
module io_input_debounce #(
  parameter int N = 1,
  parameter int D = 20000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] level,
  output logic [N-1:0] deb,
  output logic [N-1:0] rise
);
  localparam int CW = $clog2(D + 1);
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          deb_q;
    logic          hit;
    assign hit = (level[i] != deb_q) && (cnt == CW'(D - 1));
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt   <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt   <= (level[i] == deb_q || hit) ? '0 : cnt + 1'b1;
        deb_q <= hit ? level[i] : deb_q;
      end
    end
    assign deb[i]  = deb_q;
    assign rise[i] = hit & level[i];
  end
endmodule

module io_input_ctrl #(
  parameter int SW_WIDTH        = 24,
  parameter int BTN_WIDTH       = 5,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switch_in,
  input  logic [BTN_WIDTH-1:0] button_in,
  input  logic                 io_read,
  input  logic [1:0]           io_addr,
  output logic [31:0]          io_rdata,
  output logic                 io_rvalid,
  output logic                 event_pending
);
  logic [SW_WIDTH-1:0]  sw_s1, sw_s2, sw_val;
  logic [BTN_WIDTH-1:0] btn_s1, btn_s2, btn_deb, btn_rise, events;
  logic [7:0]           press_cnt;
  logic [31:0]          rdata;
  logic                 rd_ev, rd_pc, any_rise;
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= switch_in;
      sw_s2  <= sw_s1;
      btn_s1 <= button_in;
      btn_s2 <= btn_s1;
    end
  end
  io_input_debounce #(.N(BTN_WIDTH), .D(DEBOUNCE_CYCLES)) u_btn_deb (
    .clock (clock),
    .reset (reset),
    .level (btn_s2),
    .deb   (btn_deb),
    .rise  (btn_rise)
  );
`ifdef IO_INPUT_SWITCH_DEBOUNCE_EN
  logic [SW_WIDTH-1:0] sw_rise;
  io_input_debounce #(.N(SW_WIDTH), .D(DEBOUNCE_CYCLES)) u_sw_deb (
    .clock (clock),
    .reset (reset),
    .level (sw_s2),
    .deb   (sw_val),
    .rise  (sw_rise)
  );
`else
  assign sw_val = sw_s2;
`endif
  assign rd_ev         = io_read && io_addr == 2'd2;
  assign rd_pc         = io_read && io_addr == 2'd3;
  assign any_rise      = |btn_rise;
  assign event_pending = |events;
  always_comb begin
    rdata = io_addr == 2'd0 ? 32'(sw_val) :
            io_addr == 2'd1 ? 32'(btn_deb) :
            io_addr == 2'd2 ? 32'(events) : {24'b0, press_cnt};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      events    <= '0;
      press_cnt <= '0;
      io_rdata  <= '0;
      io_rvalid <= 1'b0;
    end else begin
      events    <= (rd_ev ? '0 : events) | btn_rise;
      press_cnt <= rd_pc ? {7'b0, any_rise} :
                   (any_rise && press_cnt != 8'hFF) ? press_cnt + 8'd1 : press_cnt;
      io_rdata  <= io_read ? rdata : io_rdata;
      io_rvalid <= io_read;
    end
  end
endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: scoreboard bench for io_input_ctrl with DEBOUNCE_CYCLES=4
module tb_io_input_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] switch_in;
  logic [4:0]  button_in;
  logic        io_read;
  logic [1:0]  io_addr;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        event_pending;
  int          checks = 0;
  int          errors = 0;
  typedef struct { logic [1:0] addr; logic [31:0] exp; } rd_t;
  rd_t sb[$];

  io_input_ctrl #(.SW_WIDTH(24), .BTN_WIDTH(5), .DEBOUNCE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .switch_in     (switch_in),
    .button_in     (button_in),
    .io_read       (io_read),
    .io_addr       (io_addr),
    .io_rdata      (io_rdata),
    .io_rvalid     (io_rvalid),
    .event_pending (event_pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    sb.push_back('{a, e});
    io_addr = a;
    io_read = 1'b1;
    tick();
    io_read = 1'b0;
  endtask

  always @(negedge clock) begin
    if (io_rvalid === 1'b1) begin
      if (sb.size() > 0) begin
        rd_t r;
        r = sb.pop_front();
        chk($sformatf("rd_addr%0d", r.addr), io_rdata, r.exp);
      end else
        chk("rvalid_spurious", {31'b0, io_rvalid}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1;
    switch_in = '1;
    button_in = '1;
    io_read = 1'b1;
    io_addr = 2'd1;
    repeat (3) begin
      tick();
      chk("rst_rdata", io_rdata, 32'd0);
      chk("rst_rvalid", {31'b0, io_rvalid}, 32'd0);
      chk("rst_pending", {31'b0, event_pending}, 32'd0);
    end
    reset = 1'b0;
    io_read = 1'b0;
    repeat (5) tick();
    rd(2'd1, 32'h0);
    rd(2'd1, 32'h1F);
    chk("pending_set", {31'b0, event_pending}, 32'd1);
    rd(2'd2, 32'h1F);
    chk("pending_clr", {31'b0, event_pending}, 32'd0);
    rd(2'd3, 32'd1);
    rd(2'd0, 32'h00FF_FFFF);
    button_in = '0;
    switch_in = '0;
    repeat (8) tick();
    rd(2'd1, 32'h0);
    tick();
    chk("rvalid_drop", {31'b0, io_rvalid}, 32'd0);
    rd(2'd0, 32'h0);
`ifndef IO_INPUT_SWITCH_DEBOUNCE_EN
    switch_in = 24'h008000;
    tick();
    rd(2'd0, 32'h0);
    rd(2'd0, 32'h0000_8000);
    switch_in = '0;
    repeat (4) tick();
`endif
    // bounce on button 2: only the final settled level is accepted
    button_in[2] = 1'b1; tick();
    button_in[2] = 1'b0; tick();
    button_in[2] = 1'b1; tick();
    button_in[2] = 1'b0; tick();
    button_in[2] = 1'b1;
    repeat (5) tick();
    rd(2'd1, 32'h0);
    rd(2'd1, 32'h04);
    rd(2'd2, 32'h04);
    rd(2'd3, 32'd1);
    button_in = '0;
    repeat (8) tick();
    button_in[1] = 1'b1;
    repeat (6) tick();
    button_in = '0;
    repeat (8) tick();
    button_in[0] = 1'b1;
    repeat (5) tick();
    rd(2'd2, 32'h02);
    chk("collide_pending", {31'b0, event_pending}, 32'd1);
    rd(2'd2, 32'h01);
    button_in = '0;
    repeat (8) tick();
    button_in[0] = 1'b1;
    repeat (5) tick();
    rd(2'd3, 32'd2);
    rd(2'd3, 32'd1);
    rd(2'd2, 32'h01);
    button_in = '0;
    repeat (8) tick();
    button_in = 5'h1F;
    repeat (6) tick();
    rd(2'd2, 32'h1F);
    rd(2'd3, 32'd1);
    button_in = '0;
    repeat (8) tick();
    for (int i = 0; i < 300; i++) begin
      button_in = 5'h01;
      repeat (7) tick();
      button_in = '0;
      repeat (7) tick();
    end
    rd(2'd3, 32'd255);
    rd(2'd3, 32'd0);
`ifdef IO_INPUT_SWITCH_DEBOUNCE_EN
    switch_in[23] = 1'b1; tick(); tick();
    switch_in[23] = 1'b0;
    repeat (10) tick();
    rd(2'd0, 32'h0);
    switch_in[23] = 1'b1;
    repeat (5) tick();
    rd(2'd0, 32'h0);
    rd(2'd0, 32'h0080_0000);
`endif
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
